// File: rtl/qsched_pkg.sv
// Shared types and constants for the quantizer lane scheduler.
package qsched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_WAIT_OUT = 2'd3
  } qsched_state_t;

  localparam int QSCHED_WORD_W = 32;
  localparam int QSCHED_Q_W    = 8;

  function automatic int lane_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted lane, lane 0 first after reset.
// Grant is combinational from req_i; the pointer moves only when adv_i coincides with a request.
module rr_arbiter
  import qsched_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int ID_W      = lane_id_w(NUM_LANES)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_LANES-1:0] req_i,
  input  logic                 adv_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [ID_W-1:0]      gnt_id_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_LANES);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else if (adv_i && found) begin
      if (gnt_id_o == ID_W'(NUM_LANES - 1)) ptr_q <= '0;
      else                                  ptr_q <= gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/quant_lane_scheduler.sv
// Shares one serial quantizer among NUM_LANES result lanes: grant, shift LSB-first, drain, capture.
// Optional QSCHED_STATS_EN adds capture/stall counters; core behaviour is the same either way.
module quant_lane_scheduler
  import qsched_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int WORD_W    = QSCHED_WORD_W,
  parameter  int Q_W       = QSCHED_Q_W,
  parameter  int Q_LAT     = 1,
  localparam int LANE_W    = lane_id_w(NUM_LANES)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NUM_LANES-1:0]        lane_valid_i,
  input  logic [NUM_LANES*WORD_W-1:0] lane_data_i,
  output logic [NUM_LANES-1:0]        lane_ready_o,
  output logic                        q_clear_o,
  output logic                        q_data_o,
  input  logic [Q_W-1:0]              q_result_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [Q_W-1:0]              out_data_o,
  output logic [LANE_W-1:0]           out_lane_o,
  output logic                        busy_o
`ifdef QSCHED_STATS_EN
  ,
  output logic [15:0]                 stat_words_o,
  output logic [15:0]                 stat_stall_o
`endif
);

  localparam int              CNT_W      = (WORD_W > 8) ? $clog2(WORD_W) : 3;
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((Q_LAT > 0) ? Q_LAT - 1 : 0);

  qsched_state_t        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]    sreg_q, sreg_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic                 q_data_q, q_data_d;
  logic                 q_clear_q, q_clear_d;
  logic                 out_valid_q, out_valid_d;
  logic [Q_W-1:0]       out_data_q, out_data_d;
  logic [LANE_W-1:0]    out_lane_q, out_lane_d;
  logic                 capture_pt;

  logic [NUM_LANES-1:0] gnt;
  logic [LANE_W-1:0]    gnt_id;
  logic [WORD_W-1:0]    sel_word;

  rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (lane_valid_i),
    .adv_i   (state_q == ST_IDLE),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );

  assign sel_word = lane_data_i[int'(gnt_id)*WORD_W +: WORD_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    lane_d      = lane_q;
    q_data_d    = 1'b0;
    q_clear_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    capture_pt  = 1'b0;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|lane_valid_i) begin
          // Bit 0 and the frame clear go out on the register right after the grant edge.
          sreg_d    = sel_word >> 1;
          q_data_d  = sel_word[0];
          q_clear_d = 1'b1;
          lane_d    = gnt_id;
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (Q_LAT == 0) capture_pt = 1'b1;
          else            state_d    = ST_DRAIN;
        end else begin
          q_data_d = sreg_q[0];
          sreg_d   = sreg_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) capture_pt = 1'b1;
        else                     cnt_d      = cnt_q + 1'b1;
      end
      ST_WAIT_OUT: capture_pt = 1'b1;
      default:     state_d    = ST_IDLE;
    endcase

    // A pop in the same cycle frees the buffer, so capture may overwrite it directly.
    if (capture_pt) begin
      if (!out_valid_q || out_ready_i) begin
        out_valid_d = 1'b1;
        out_data_d  = q_result_i;
        out_lane_d  = lane_q;
        state_d     = ST_IDLE;
      end else begin
        state_d = ST_WAIT_OUT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      lane_q      <= '0;
      q_data_q    <= 1'b0;
      q_clear_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      lane_q      <= lane_d;
      q_data_q    <= q_data_d;
      q_clear_q   <= q_clear_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
    end
  end

  assign lane_ready_o = (state_q == ST_IDLE) ? gnt : '0;
  assign q_clear_o    = q_clear_q;
  assign q_data_o     = q_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_lane_o   = out_lane_q;
  assign busy_o       = (state_q != ST_IDLE);

`ifdef QSCHED_STATS_EN
  logic [15:0] stat_words_q, stat_stall_q;

  // Leaving a busy state for IDLE only ever happens through a capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_d == ST_IDLE) stat_words_q <= stat_words_q + 16'd1;
      if (state_q == ST_WAIT_OUT && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_words_o = stat_words_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_quant_lane_scheduler.sv
// Scoreboard bench for quant_lane_scheduler with a ReLU + bits[18:11] quantizer model (Q_LAT=1).
module tb_quant_lane_scheduler;
  import qsched_pkg::*;

  localparam int NL = 4;
  localparam int WW = 32;
  localparam int QW = 8;
  localparam int QL = 1;
  localparam int LW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NL-1:0]    lane_valid = '0;
  logic [NL*WW-1:0] lane_data;
  logic [NL-1:0]    lane_ready;
  logic             q_clear, q_data;
  logic [QW-1:0]    q_result = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [QW-1:0]    out_data;
  logic [LW-1:0]    out_lane;
  logic             busy;
`ifdef QSCHED_STATS_EN
  logic [15:0]      stat_words, stat_stall;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  quant_lane_scheduler #(.NUM_LANES(NL), .WORD_W(WW), .Q_W(QW), .Q_LAT(QL)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .lane_valid_i(lane_valid),
    .lane_data_i (lane_data),
    .lane_ready_o(lane_ready),
    .q_clear_o   (q_clear),
    .q_data_o    (q_data),
    .q_result_i  (q_result),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_lane_o  (out_lane),
    .busy_o      (busy)
`ifdef QSCHED_STATS_EN
    ,
    .stat_words_o(stat_words),
    .stat_stall_o(stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Quantizer model: frames on q_clear, result one cycle after the last bit.
  logic [31:0] acc = '0;
  int          nbits = WW;
  always @(posedge clk) begin
    if (q_clear) begin
      acc   = {31'b0, q_data};
      nbits = 1;
    end else if (nbits < WW) begin
      acc[nbits] = q_data;
      nbits++;
      if (nbits == WW) q_result <= acc[31] ? 8'h00 : acc[18:11];
    end
  end

  // Scoreboard: expected results pushed by stimulus, popped on every accepted output.
  int exp_lane[$];
  int exp_data[$];
  int el, ed;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_lane.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got lane %0d data 0x%02h, required no output", out_lane, out_data);
      end else begin
        el = exp_lane.pop_front();
        ed = exp_data.pop_front();
        if (int'(out_lane) != el || int'(out_data) != ed) begin
          fails++;
          $display("FAIL sb_result: got lane %0d data 0x%02h, required lane %0d data 0x%02h",
                   out_lane, out_data, el, ed);
        end
      end
    end
  end

  // Grant monitor: records lane and cycle of each grant, checks one-hot.
  int g_lane[$];
  int g_cyc[$];
  always @(negedge clk) begin
    if (rst_n && |lane_ready) begin
      int gi;
      gi = 0;
      for (int i = 0; i < NL; i++) if (lane_ready[i]) gi = i;
      g_lane.push_back(gi);
      g_cyc.push_back(cyc);
      tests++;
      if ($countones(lane_ready) != 1) begin
        fails++;
        $display("FAIL grant_onehot: got 0x%0h, required one bit set", lane_ready);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      nstep();
      if (g_lane.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got %0d grants, required %0d", g_lane.size(), n);
    end
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_lane.size() != 0; i++) nstep();
    check("sb_drained", exp_lane.size(), 0);
  endtask

  task automatic push_exp(input int lane, input int data);
    exp_lane.push_back(lane);
    exp_data.push_back(data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lane_ready"}, lane_ready, 0);
    check({tag, "_q_clear"}, q_clear, 0);
    check({tag, "_q_data"}, q_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_lane"}, out_lane, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, k, nclr, clr_off, ov_off, nwait, exp_wait, wstart, rel_cyc;
    logic [31:0] sw;
    int          exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    lane_data = {32'h00FF_0000, 32'h0001_2345, 32'h0007_F800, 32'h0000_2800};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;

    // Lane 0, 0x2800 -> 0x05: timing of clear, serial order and result
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_exp(0, 8'h05);
    lane_valid = 4'b0001;
    wait_grants(1, 50);
    t0 = (g_cyc.size() > 0) ? g_cyc[0] : cyc;
    check("a_grant_lane", (g_lane.size() > 0) ? g_lane[0] : -1, 0);
    @(posedge clk); #1;
    lane_valid = '0;
    nclr = 0; clr_off = -1; ov_off = -1; sw = '0;
    for (int i = 0; i < 40; i++) begin
      nstep();
      k = cyc - t0;
      if (q_clear) begin nclr++; clr_off = k; end
      if (k >= 1 && k <= WW) sw[k-1] = q_data;
      if (out_valid && ov_off < 0) ov_off = k;
    end
    check("a_clear_count", nclr, 1);
    check("a_clear_cycle", clr_off, 1);
    check("a_serial_word", sw, 32'h0000_2800);
    check("a_out_valid_cycle", ov_off, WW + QL + 1);

    // Lane 2 negative word -> ReLU gives 0
    lane_data[2*WW +: WW] = 32'hFFFF_FFF6;
    @(posedge clk); #1;
    push_exp(2, 8'h00);
    lane_valid = 4'b0100;
    wait_grants(2, 50);
    check("b_grant_lane", (g_lane.size() > 1) ? g_lane[1] : -1, 2);
    @(posedge clk); #1;
    lane_valid = '0;
    wait_empty(60);
    lane_data[2*WW +: WW] = 32'h0001_2345;

    // Reset while lane 1's word is at bit 10
    @(posedge clk); #1;
    lane_valid = 4'b0010;
    wait_grants(3, 50);
    t0 = (g_cyc.size() > 2) ? g_cyc[2] : cyc;
    @(posedge clk); #1;
    lane_valid = '0;
    for (int i = 0; i < 20 && (cyc - t0) < 11; i++) nstep();
    check("d_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("d");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    g_lane.delete();
    g_cyc.delete();

    // All lanes valid: 0,1,2,3,0 at the best-case spacing
    for (int i = 0; i < 5; i++) push_exp(exp_order[i], (i == 1) ? 8'hFF : (i == 2) ? 8'h24 : (i == 3) ? 8'hE0 : 8'h05);
    @(posedge clk); #1;
    lane_valid = 4'b1111;
    wait_grants(5, 300);
    @(posedge clk); #1;
    lane_valid = '0;
    for (int i = 0; i < 5 && i < g_lane.size(); i++) begin
      check($sformatf("c_grant%0d_lane", i), g_lane[i], exp_order[i]);
      if (i > 0) check($sformatf("c_grant%0d_gap", i), g_cyc[i] - g_cyc[i-1], WW + QL + 1);
    end
    wait_empty(100);

    // Output stall: second word parks in WAIT_OUT, third lane is not granted
    @(posedge clk); #1;
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    g_lane.delete();
    g_cyc.delete();
    push_exp(1, 8'hFF);
    push_exp(2, 8'h24);
    push_exp(3, 8'hE0);
    @(posedge clk); #1;
    lane_valid = 4'b1110;
    for (int i = 0; i < 100 && !out_valid; i++) nstep();
    check("e_first_result_valid", out_valid, 1);
    nwait = 0;
    for (int i = 0; i < 100; i++) begin
      nstep();
      if (dut.state_q == ST_WAIT_OUT) nwait++;
    end
    check("e_grants_during_stall", g_lane.size(), 2);
    check("e_state_wait_out", dut.state_q, ST_WAIT_OUT);
    check("e_held_lane", out_lane, 1);
    check("e_held_data", out_data, 8'hFF);
    wstart = (g_cyc.size() > 1) ? g_cyc[1] + WW + QL + 1 : 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    rel_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      nstep();
      if (dut.state_q == ST_WAIT_OUT) nwait++;
      else break;
    end
    exp_wait = rel_cyc - wstart + 1;
    check("e_wait_cycles", nwait, exp_wait);
`ifdef QSCHED_STATS_EN
    check("e_stat_words", stat_words, 2);
    check("e_stat_stall", stat_stall, exp_wait);
`endif
    wait_grants(3, 100);
    check("e_third_grant_lane", (g_lane.size() > 2) ? g_lane[2] : -1, 3);
    @(posedge clk); #1;
    lane_valid = '0;
    wait_empty(100);

    repeat (5) nstep();
    check("final_sb_empty", exp_lane.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
